// File: rtl/team_06_effect_engine.sv
`default_nettype none
//============================================================================
// Module   : team_06_effect_engine
// Purpose  : Transmit-path audio effect processor. Applies NORMAL, ECHO,
//            TREMOLO, REVERB or SOFT to 8-bit offset-binary mic samples
//            (128 = silence). It holds a delay-line RAM for ECHO/REVERB and
//            a triangle LFO for TREMOLO. Output is muted while in LIST.
// Ports    : clk            system clock
//            rst            asynchronous active-high reset
//            state          1 = TALK, 0 = LIST
//            current_effect 000 NORMAL, 001 ECHO, 010 TREMOLO, 011 REVERB,
//                           100 SOFT, others NORMAL
//            mic_aud        offset-binary mic sample
//            mic_valid      one-cycle strobe qualifying mic_aud
//            fx_aud         processed offset-binary sample (registered)
//            fx_valid       one-cycle strobe, one cycle after accepted input
//            busy           high while the delay line is being cleared
// Options  : TEAM06_SOFT_KNEE_EN - SOFT becomes a soft-knee limiter
//            (knee at |s| = 32, slope 1/4 above); otherwise SOFT halves.
// Revision : 1.0 - initial release
//============================================================================
module team_06_effect_engine #(
    parameter int DELAY_DEPTH = 256,
    parameter int TREM_DIV    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       state,
    input  logic [2:0] current_effect,
    input  logic [7:0] mic_aud,
    input  logic       mic_valid,
    output logic [7:0] fx_aud,
    output logic       fx_valid,
    output logic       busy
);

    localparam int AW = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;
    localparam int DW = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DELAY_DEPTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TREM_DIV - 1);

    localparam logic [2:0] FX_NORMAL = 3'b000;
    localparam logic [2:0] FX_ECHO   = 3'b001;
    localparam logic [2:0] FX_TREM   = 3'b010;
    localparam logic [2:0] FX_REVERB = 3'b011;
    localparam logic [2:0] FX_SOFT   = 3'b100;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fsm_t;

    // Clamp a wide signed intermediate into the 8-bit signed range.
    function automatic logic signed [7:0] sat8(input logic signed [12:0] v);
        if (v > 13'sd127)
            sat8 = 8'sh7F;
        else if (v < -13'sd128)
            sat8 = 8'sh80;
        else
            sat8 = v[7:0];
    endfunction

    fsm_t              fsm_q, fsm_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [2:0]        prev_fx_q;
    logic [3:0]        lfo_q, lfo_d;
    logic              lfo_down_q, lfo_down_d;
    logic [DW-1:0]     div_q, div_d;
    logic [7:0]        fx_aud_q, fx_aud_d;
    logic              fx_valid_q, fx_valid_d;

    logic [7:0]        mem_q [DELAY_DEPTH];
    logic              ram_we_w;
    logic [7:0]        ram_wdata_w;

    logic signed [7:0]  s_w;
    logic [7:0]         tap_w;
    logic signed [12:0] s13_w;
    logic signed [12:0] d13_w;
    logic signed [12:0] sum13_w;
    logic signed [7:0]  mix_w;
    logic signed [12:0] prod_w;
    logic signed [12:0] soft13_w;
    logic signed [12:0] y13_w;
    logic signed [7:0]  y_w;
    logic [7:0]         wdata_w;
    logic               clear_trig_w;
    logic               trem_entry_w;
    logic [3:0]         lfo_use_w;
    logic               down_use_w;
    logic [DW-1:0]      div_use_w;

    // Signed view of the sample and the delay tap, widened for headroom.
    assign s_w     = $signed(mic_aud ^ 8'h80);
    assign tap_w   = mem_q[ptr_q];
    assign s13_w   = $signed({{5{s_w[7]}}, s_w});
    assign d13_w   = $signed({{5{tap_w[7]}}, tap_w});
    assign sum13_w = s13_w + (d13_w >>> 1);
    assign mix_w   = sat8(sum13_w);

    // Clearing is needed only when moving from a non-delay effect into a
    // delay effect; ECHO <-> REVERB keeps the existing history.
    assign clear_trig_w = ((current_effect == FX_ECHO) || (current_effect == FX_REVERB)) &&
                          !((prev_fx_q == FX_ECHO) || (prev_fx_q == FX_REVERB));

    // On entry to TREMOLO the LFO restarts from the top, and a sample landing
    // in that same cycle already sees the restarted values.
    assign trem_entry_w = (current_effect == FX_TREM) && (prev_fx_q != FX_TREM);
    assign lfo_use_w    = trem_entry_w ? 4'd15 : lfo_q;
    assign down_use_w   = trem_entry_w ? 1'b1  : lfo_down_q;
    assign div_use_w    = trem_entry_w ? '0    : div_q;

    assign prod_w = s13_w * $signed({9'd0, lfo_use_w});

`ifdef TEAM06_SOFT_KNEE_EN
    logic [8:0] abs_w;
    logic [8:0] mag_w;
    assign abs_w    = s_w[7] ? (9'd0 - {1'b1, s_w}) : {1'b0, s_w};
    assign mag_w    = (abs_w <= 9'd32) ? abs_w : (9'd32 + ((abs_w - 9'd32) >> 2));
    assign soft13_w = s_w[7] ? -$signed({4'd0, mag_w}) : $signed({4'd0, mag_w});
`else
    assign soft13_w = s13_w >>> 1;
`endif

    always_comb begin
        y13_w = s13_w;
        case (current_effect)
            FX_ECHO, FX_REVERB: y13_w = sum13_w;
            FX_TREM:            y13_w = prod_w >>> 4;
            FX_SOFT:            y13_w = soft13_w;
            default:            y13_w = s13_w;
        endcase
    end

    assign y_w = sat8(y13_w);

    // LIST silences the history too; REVERB feeds its own output back.
    always_comb begin
        wdata_w = s_w;
        if (!state)
            wdata_w = 8'h00;
        else if (current_effect == FX_REVERB)
            wdata_w = mix_w;
    end

    always_comb begin
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        lfo_d       = lfo_use_w;
        lfo_down_d  = down_use_w;
        div_d       = div_use_w;
        fx_aud_d    = fx_aud_q;
        fx_valid_d  = 1'b0;
        ram_we_w    = 1'b0;
        ram_wdata_w = 8'h00;
        case (fsm_q)
            ST_CLEAR: begin
                ram_we_w = 1'b1;
                ptr_d    = ptr_q + AW'(1);
                if (ptr_q == PTR_LAST)
                    fsm_d = ST_RUN;
            end
            ST_RUN: begin
                if (clear_trig_w) begin
                    fsm_d = ST_CLEAR;
                    ptr_d = '0;
                end else if (mic_valid) begin
                    ram_we_w    = 1'b1;
                    ram_wdata_w = wdata_w;
                    ptr_d       = ptr_q + AW'(1);
                    fx_valid_d  = 1'b1;
                    fx_aud_d    = state ? (y_w ^ 8'h80) : 8'h80;
                    if (current_effect == FX_TREM) begin
                        if (div_use_w == DIV_LAST) begin
                            div_d = '0;
                            if (down_use_w) begin
                                if (lfo_use_w == 4'd0) begin
                                    lfo_d      = 4'd1;
                                    lfo_down_d = 1'b0;
                                end else begin
                                    lfo_d = lfo_use_w - 4'd1;
                                end
                            end else begin
                                if (lfo_use_w == 4'd15) begin
                                    lfo_d      = 4'd14;
                                    lfo_down_d = 1'b1;
                                end else begin
                                    lfo_d = lfo_use_w + 4'd1;
                                end
                            end
                        end else begin
                            div_d = div_use_w + DW'(1);
                        end
                    end
                end
            end
            default: fsm_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_CLEAR;
            ptr_q      <= '0;
            prev_fx_q  <= FX_NORMAL;
            lfo_q      <= 4'd15;
            lfo_down_q <= 1'b1;
            div_q      <= '0;
            fx_aud_q   <= 8'h80;
            fx_valid_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            ptr_q      <= ptr_d;
            prev_fx_q  <= current_effect;
            lfo_q      <= lfo_d;
            lfo_down_q <= lfo_down_d;
            div_q      <= div_d;
            fx_aud_q   <= fx_aud_d;
            fx_valid_q <= fx_valid_d;
        end
    end

    // Delay-line storage; contents are initialised by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (ram_we_w)
            mem_q[ptr_q] <= ram_wdata_w;
    end

    assign fx_aud   = fx_aud_q;
    assign fx_valid = fx_valid_q;
    assign busy     = (fsm_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_team_06_effect_engine.sv
`default_nettype none
//============================================================================
// Module   : tb_team_06_effect_engine
// Purpose  : Directed self-checking bench for team_06_effect_engine, built
//            with a 4-word delay line and a tremolo step on every sample.
// Revision : 1.0 - initial release
//============================================================================
module tb_team_06_effect_engine;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       state;
    logic [2:0] current_effect;
    logic [7:0] mic_aud;
    logic       mic_valid;
    logic [7:0] fx_aud;
    logic       fx_valid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    team_06_effect_engine #(
        .DELAY_DEPTH (DEPTH),
        .TREM_DIV    (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .current_effect (current_effect),
        .mic_aud        (mic_aud),
        .mic_valid      (mic_valid),
        .fx_aud         (fx_aud),
        .fx_valid       (fx_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One accepted sample; output is checked one cycle later.
    task automatic sample(input logic [2:0] eff, input logic [7:0] a,
                          input logic [7:0] exp, input string tag);
        @(negedge clk);
        current_effect = eff;
        mic_aud        = a;
        mic_valid      = 1'b1;
        @(posedge clk);
        #1;
        mic_valid = 1'b0;
        check({tag, "_valid"}, fx_valid, 1);
        check(tag, fx_aud, exp);
    endtask

    task automatic set_fx(input logic [2:0] eff);
        @(negedge clk);
        current_effect = eff;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Count busy cycles from a reset release, pulsing mic_valid throughout.
    task automatic count_clear(input string tag);
        int cnt;
        logic saw_fx;
        cnt    = 0;
        saw_fx = 1'b0;
        mic_valid = 1'b1;
        mic_aud   = 8'd200;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cnt++;
            if (fx_valid) saw_fx = 1'b1;
            @(negedge clk);
        end
        mic_valid = 1'b0;
        check({tag, "_busy_len"}, cnt, DEPTH);
        check({tag, "_no_fx"}, saw_fx, 0);
    endtask

    localparam logic [7:0] REV_EXP [13] = '{8'd192, 8'd128, 8'd128, 8'd128,
                                            8'd160, 8'd128, 8'd128, 8'd128,
                                            8'd144, 8'd128, 8'd128, 8'd128,
                                            8'd136};
    localparam logic [7:0] SOFT_IN [7]  = '{8'd255, 8'd0, 8'd129, 8'd127,
                                            8'd160, 8'd161, 8'd200};
`ifdef TEAM06_SOFT_KNEE_EN
    localparam logic [7:0] SOFT_EXP [7] = '{8'd183, 8'd72, 8'd129, 8'd127,
                                            8'd160, 8'd160, 8'd170};
`else
    localparam logic [7:0] SOFT_EXP [7] = '{8'd191, 8'd64, 8'd128, 8'd127,
                                            8'd144, 8'd144, 8'd164};
`endif

    initial begin
        int lv;
        rst            = 1'b1;
        state          = 1'b1;
        current_effect = 3'b001;
        mic_aud        = 8'd128;
        mic_valid      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_fx_valid", fx_valid, 0);
        check("rst_fx_aud", fx_aud, 128);

        @(negedge clk);
        rst = 1'b0;
        count_clear("init");

        // NORMAL pass-through and LIST mute
        sample(3'b000, 8'd200, 8'd200, "normal");
        state = 1'b0;
        sample(3'b000, 8'd200, 8'd128, "list_mute");
        @(posedge clk);
        #1;
        check("one_pulse", fx_valid, 0);
        state = 1'b1;

        // Change into ECHO with a sample in the same cycle: sample dropped
        @(negedge clk);
        current_effect = 3'b001;
        mic_aud        = 8'd255;
        mic_valid      = 1'b1;
        @(posedge clk);
        #1;
        mic_valid = 1'b0;
        check("drop_on_clr_valid", fx_valid, 0);
        check("drop_on_clr_busy", busy, 1);
        wait_idle("echo");

        // ECHO impulse response, then positive and negative saturation
        sample(3'b001, 8'd192, 8'd192, "echo0");
        sample(3'b001, 8'd128, 8'd128, "echo1");
        sample(3'b001, 8'd128, 8'd128, "echo2");
        sample(3'b001, 8'd128, 8'd128, "echo3");
        sample(3'b001, 8'd128, 8'd160, "echo4");
        sample(3'b001, 8'd255, 8'd255, "echo_sat_a");
        sample(3'b001, 8'd128, 8'd128, "echo_s1");
        sample(3'b001, 8'd128, 8'd128, "echo_s2");
        sample(3'b001, 8'd128, 8'd128, "echo_s3");
        sample(3'b001, 8'd255, 8'd255, "echo_sat_b");
        sample(3'b001, 8'd0,   8'd0,   "echo_neg_a");
        sample(3'b001, 8'd128, 8'd128, "echo_n1");
        sample(3'b001, 8'd128, 8'd128, "echo_n2");
        sample(3'b001, 8'd128, 8'd191, "echo_tap127");
        sample(3'b001, 8'd0,   8'd0,   "echo_neg_sat");

        // ECHO -> REVERB keeps the history
        set_fx(3'b011);
        @(posedge clk);
        #1;
        check("e2r_noclr", busy, 0);

        // NORMAL -> REVERB clears, then impulse with feedback
        set_fx(3'b000);
        set_fx(3'b011);
        @(posedge clk);
        #1;
        check("rev_clr", busy, 1);
        wait_idle("rev");
        for (int i = 0; i < 13; i++)
            sample(3'b011, (i == 0) ? 8'd192 : 8'd128, REV_EXP[i], $sformatf("rev%0d", i));

        // TREMOLO entered on the first sample: 15..0 then rising
        for (int i = 0; i < 20; i++) begin
            lv = (i <= 15) ? (15 - i) : (i - 15);
            sample(3'b010, 8'd192, 8'(128 + 4 * lv), $sformatf("trem%0d", i));
        end
        sample(3'b010, 8'd127, 8'd127, "trem_floor");
        sample(3'b010, 8'd0,   8'd80,  "trem_neg");

        // SOFT
        for (int i = 0; i < 7; i++)
            sample(3'b100, SOFT_IN[i], SOFT_EXP[i], $sformatf("soft%0d", i));

        // Undefined codes behave as NORMAL
        sample(3'b101, 8'd77, 8'd77, "code5");
        sample(3'b111, 8'd10, 8'd10, "code7");

        // Output holds between strobes; async reset during a clear
        set_fx(3'b001);
        @(posedge clk);
        #1;
        check("clr2", busy, 1);
        wait_idle("clr2");
        sample(3'b001, 8'd200, 8'd200, "pre_rst");
        set_fx(3'b000);
        set_fx(3'b001);
        @(posedge clk);
        #1;
        check("hold_aud", fx_aud, 200);
        check("clr3", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_aud", fx_aud, 128);
        check("async_valid", fx_valid, 0);
        check("async_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        count_clear("rerst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/team_06_effect_engine.md
Name: team_06_effect_engine

Overview:
Audio effect processor on the transmit path. It consumes the talk/listen state and the effect code from the control FSM, and applies that effect to the 8-bit offset-binary mic samples (128 = silence). It holds a delay-line RAM for ECHO and REVERB and an LFO for TREMOLO. Output feeds the transmit serializer.

Parameters:
DELAY_DEPTH, 256, delay-line length in samples (power of 2, at least 4)
TREM_DIV, 32, valid samples per tremolo LFO step (at least 1)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
state  input  1  1 = TALK, 0 = LIST
current_effect  input  3  000 NORMAL, 001 ECHO, 010 TREMOLO, 011 REVERB, 100 SOFT, others treated as NORMAL
mic_aud  input  8  offset-binary mic sample
mic_valid  input  1  one-cycle strobe, mic_aud valid
fx_aud  output  8  processed offset-binary sample
fx_valid  output  1  one-cycle strobe, fx_aud valid
busy  output  1  high while the delay line is being cleared

Behaviour:
- Reset values: fx_aud=128, fx_valid=0, busy=1, LFO=15 counting down, LFO divider=0, pointer=0. The FSM enters CLEAR.
- FSM states are CLEAR and RUN.
- CLEAR: each cycle writes 0 at the pointer and increments it. After DELAY_DEPTH cycles (pointer wraps to 0) the FSM goes to RUN and busy falls in the same cycle.
  - mic_valid during CLEAR drops the sample; no fx_valid is produced.
- RUN: when current_effect changes into 001 or 011 from any other code, the FSM returns to CLEAR on the next cycle. Changes between 001 and 011 do not trigger a clear.
- Signed domain: s = mic_aud - 128 (9-bit signed). Result y is saturated to [-128, 127]; fx_aud = y + 128.
- Latency: fx_valid rises exactly 1 cycle after an accepted mic_valid, with fx_aud registered in that cycle. There are no other fx_valid pulses.
- Delay tap: d = RAM[ptr] is the word written DELAY_DEPTH accepted samples earlier. Each accepted sample reads then writes RAM[ptr], then ptr increments mod DELAY_DEPTH.
- Effects:
  - NORMAL: y = s.
  - ECHO: y = sat(s + (d>>>1)); RAM writes s.
  - REVERB: w = sat(s + (d>>>1)); y = w; RAM writes w (feedback).
  - TREMOLO: y = (s*lfo)>>>4, floor. The LFO is a 0..15 triangle that reverses at the ends and steps once every TREM_DIV accepted samples. Entering TREMOLO reloads lfo=15 (down) and divider=0.
  - SOFT: y = s>>>1.
  - In NORMAL, TREMOLO and SOFT the RAM still writes s and ptr still advances, so the history stays continuous.
- LIST (state=0): fx_aud=128 on every fx_valid, and RAM writes 0.
  - The state is sampled on the accepted mic_valid cycle, so a TALK to LIST change mutes the very next output.
- A mic_valid in the same cycle as an effect change uses the new code. A clear-triggering change discards that sample.
- Asserting rst mid-operation aborts any clear or sample in flight and returns to the reset values.

Optional Feature:
TEAM06_SOFT_KNEE_EN
- Defined: SOFT becomes a soft-knee limiter.
  - |s| <= 32: y = s.
  - |s| > 32: y = sign(s)*(32 + ((|s|-32)>>2)).
- Undefined: SOFT is y = s>>>1.
- Nothing else changes.

Test Plan:
- Reset, then hold 256 cycles -> busy=1 for exactly 256 cycles, then 0; fx_valid never asserts during CLEAR even with mic_valid pulsing.
- NORMAL, TALK, mic_aud=200 -> fx_valid one cycle later, fx_aud=200; same stimulus with state=0 -> fx_aud=128.
- DELAY_DEPTH=4, ECHO, samples 192,128,128,128,128 -> outputs 192,128,128,128,160 (64 + 64>>>1 = 96, giving 224 on a repeat of 192); saturation check with two 255 inputs 4 apart -> 255.
- REVERB, DELAY_DEPTH=4, single 192 impulse then silence -> 192, then 160, 144, 136 at 4-sample intervals.
- TREMOLO, TREM_DIV=1, constant mic_aud=192 -> fx_aud 188,184,180,... down to 128 at lfo=0, then rising back.
- SOFT, mic_aud=255 -> 191 without macro; with macro -> 32+(127-32)/4 = 55, giving 183.
